pc_contexto: RTL and testbench

Multi-process program counter for the OS-capable processor core. It replaces the single-context PC with per-process saved-PC slots, a kernel entry vector and a BIOS boot vector. Address width, process count and vectors are parametrised. It sits between the control unit, which drives the `flag` and `novoendereco` inputs, and instruction memory, which consumes `endereco`.

---
 rtl/pc_contexto.sv | 147 ++++++++++++++
 tb/tb_pc_contexto.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_contexto.sv
// Multi-process program counter: per-process saved-PC slots, kernel entry and BIOS boot vectors.
// Optional quantum preemption is compiled in when PC_QUANTUM_EN is defined.
module pc_contexto_slot #(
    parameter int AW = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] q
);
    always_ff @(negedge clock or negedge reset) begin
        if (!reset)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module pc_contexto #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int NPROC    = 4,
    parameter int BIOS_VEC = 0,
    parameter int ISR_VEC  = 90,
    parameter int QUANTUM  = 64,
    localparam int PW      = $clog2(NPROC)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          resetBIOS,
    input  logic [1:0]    flag,
    input  logic [DW-1:0] novoendereco,
    input  logic          CSe,
    input  logic          retorno,
    input  logic [PW-1:0] procNovo,
    input  logic          wrSlot,
    input  logic [PW-1:0] wrIdx,
    output logic [AW-1:0] endereco,
    output logic [PW-1:0] procAtual,
    output logic [1:0]    modo,
    output logic          erro,
    output logic          preempcao
);
    typedef enum logic [1:0] {BIOS = 2'b00, KERNEL = 2'b01, USER = 2'b10} modo_t;

    modo_t                      state, state_nx;
    logic [AW-1:0]              pc_nx, npc, restore_pc, jump_tgt;
    logic [PW-1:0]              proc_nx;
    logic                       erro_nx, preempt_nx;
    logic                       in_user, expire, do_switch, do_restore, bad_ret, wr_ok;
    logic [NPROC-1:0]           slot_we, save_hit;
    logic [NPROC-1:0][AW-1:0]   slot_d, slot_q;
    logic                       unused_hi;

    assign jump_tgt  = novoendereco[AW-1:0];
    assign unused_hi = ^novoendereco[DW-1:AW];
    assign in_user   = (state == USER);

    always_comb begin
        unique case (flag)
            2'b00:   npc = endereco + AW'(1);
            2'b01:   npc = jump_tgt;
            default: npc = endereco;
        endcase
    end

`ifdef PC_QUANTUM_EN
    localparam int QW = $clog2(QUANTUM);
    logic [QW-1:0] qcnt;

    assign expire = in_user && (qcnt == QW'(QUANTUM - 1));

    // Counts USER edges since the last restore; the restore edge itself is count zero.
    always_ff @(negedge clock or negedge reset) begin
        if (!reset)          qcnt <= '0;
        else if (do_restore) qcnt <= '0;
        else if (in_user)    qcnt <= qcnt + QW'(1);
    end
`else
    assign expire = 1'b0;
`endif

    // Slot mux by loop so out-of-range process numbers never index past the array.
    always_comb begin
        restore_pc = '0;
        for (int i = 0; i < NPROC; i++)
            if (procNovo == PW'(i)) restore_pc = slot_q[i];
    end

    assign do_switch  = !resetBIOS && in_user && (CSe || expire);
    assign do_restore = !resetBIOS && !in_user && retorno && (int'(procNovo) < NPROC);
    assign bad_ret    = !resetBIOS && !in_user && retorno && (int'(procNovo) >= NPROC);
    assign wr_ok      = wrSlot && !in_user && (int'(wrIdx) < NPROC);
    assign erro_nx    = bad_ret || (wrSlot && !wr_ok);
    assign preempt_nx = do_switch && expire;

    always_comb begin
        state_nx = state;
        pc_nx    = npc;
        proc_nx  = procAtual;
        if (resetBIOS) begin
            state_nx = BIOS;
            pc_nx    = AW'(BIOS_VEC);
        end else if (do_switch) begin
            state_nx = KERNEL;
            pc_nx    = AW'(ISR_VEC);
        end else if (do_restore) begin
            state_nx = USER;
            pc_nx    = restore_pc;
            proc_nx  = procNovo;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state     <= BIOS;
            endereco  <= AW'(BIOS_VEC);
            procAtual <= '0;
            erro      <= 1'b0;
            preempcao <= 1'b0;
        end else begin
            state     <= state_nx;
            endereco  <= pc_nx;
            procAtual <= proc_nx;
            erro      <= erro_nx;
            preempcao <= preempt_nx;
        end
    end

    assign modo = state;

    // A switch save beats a same-edge wrSlot to the same slot.
    genvar g;
    generate
        for (g = 0; g < NPROC; g++) begin : g_slot
            assign save_hit[g] = do_switch && (procAtual == PW'(g));
            assign slot_we[g]  = save_hit[g] || (wr_ok && (wrIdx == PW'(g)));
            assign slot_d[g]   = save_hit[g] ? npc : jump_tgt;
            pc_contexto_slot #(.AW(AW)) u_slot (
                .clock (clock),
                .reset (reset),
                .we    (slot_we[g]),
                .d     (slot_d[g]),
                .q     (slot_q[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_pc_contexto.sv
// Directed plus randomized check of pc_contexto against an abstract process/PC model.
module tb_pc_contexto;
    localparam int AW = 10, DW = 32, NPROC = 5, PW = 3, QUANTUM = 8, ISR = 90;
`ifdef PC_QUANTUM_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clock = 1'b1, reset = 1'b0, resetBIOS = 1'b0, CSe = 1'b0, retorno = 1'b0, wrSlot = 1'b0;
    logic [1:0] flag = 2'b00;
    logic [DW-1:0] novoendereco = '0;
    logic [PW-1:0] procNovo = '0, wrIdx = '0;
    logic [AW-1:0] endereco;
    logic [PW-1:0] procAtual;
    logic [1:0] modo;
    logic erro, preempcao;

    int checks = 0, errors = 0;
    int m_pc, m_mode, m_proc, m_erro, m_pre, m_ucnt;
    int m_slot [NPROC];

    pc_contexto #(.AW(AW), .DW(DW), .NPROC(NPROC), .BIOS_VEC(0), .ISR_VEC(ISR), .QUANTUM(QUANTUM)) dut (
        .clock(clock), .reset(reset), .resetBIOS(resetBIOS), .flag(flag), .novoendereco(novoendereco),
        .CSe(CSe), .retorno(retorno), .procNovo(procNovo), .wrSlot(wrSlot), .wrIdx(wrIdx),
        .endereco(endereco), .procAtual(procAtual), .modo(modo), .erro(erro), .preempcao(preempcao));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_mode = 0; m_proc = 0; m_erro = 0; m_pre = 0; m_ucnt = 0;
        foreach (m_slot[i]) m_slot[i] = 0;
    endtask

    // One falling edge of the spec's rules: mode 0 BIOS, 1 KERNEL, 2 USER.
    task automatic model_step();
        int npc, tgt;
        bit user, exp_q;
        int nslot [NPROC];
        tgt   = novoendereco % (1 << AW);
        npc   = (flag == 2'b00) ? (m_pc + 1) % (1 << AW) : (flag == 2'b01) ? tgt : m_pc;
        user  = (m_mode == 2);
        exp_q = QEN && user && (m_ucnt == QUANTUM - 1);
        nslot = m_slot;
        m_erro = 0; m_pre = 0;
        if (wrSlot) begin
            if (user || wrIdx >= NPROC) m_erro = 1;
            else nslot[wrIdx] = tgt;
        end
        if (user) m_ucnt++;
        if (resetBIOS) begin
            m_pc = 0; m_mode = 0;
        end else if (user && (CSe || exp_q)) begin
            nslot[m_proc] = npc; m_pc = ISR; m_mode = 1; m_pre = exp_q;
        end else if (!user && retorno && procNovo < NPROC) begin
            m_pc = m_slot[procNovo]; m_proc = procNovo; m_mode = 2; m_ucnt = 0;
        end else begin
            if (!user && retorno) m_erro = 1;
            m_pc = npc;
        end
        m_slot = nslot;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".endereco"}, 32'(endereco), m_pc);
        chk({tag, ".procAtual"}, 32'(procAtual), m_proc);
        chk({tag, ".modo"}, 32'(modo), m_mode);
        chk({tag, ".erro"}, 32'(erro), m_erro);
        chk({tag, ".preempcao"}, 32'(preempcao), m_pre);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(negedge clock);
        @(posedge clock);
        check_all(tag);
        resetBIOS = 0; CSe = 0; retorno = 0; wrSlot = 0;
    endtask

    initial begin
        model_reset();
        #2 check_all("reset");
        chk("reset.endereco_const", 32'(endereco), 0);
        @(posedge clock);
        reset = 1;

        flag = 2'b00;
        for (int i = 1; i <= 5; i++) begin
            cycle("boot_inc");
            chk("boot_inc.value", 32'(endereco), i);
        end

        // Enter USER on process 0, trap to kernel, then stage process 2.
        retorno = 1; procNovo = 0; cycle("restore0");
        CSe = 1; cycle("trap0");
        chk("trap0.isr", 32'(endereco), ISR);
        flag = 2'b10; wrSlot = 1; wrIdx = 2; novoendereco = 32'h100; cycle("wrslot2");
        retorno = 1; procNovo = 2; cycle("restore2");
        chk("restore2.pc", 32'(endereco), 32'h100);
        chk("restore2.proc", 32'(procAtual), 2);
        chk("restore2.modo", 32'(modo), 2);

        flag = 2'b00;
        repeat (5) cycle("user_inc");
        chk("user_inc.pc", 32'(endereco), 32'h105);
        flag = 2'b01; novoendereco = 32'h1F0; CSe = 1; cycle("trap_jump");
        chk("trap_jump.modo", 32'(modo), 1);
        flag = 2'b10; retorno = 1; procNovo = 2; cycle("resume2");
        chk("resume2.pc", 32'(endereco), 32'h1F0);

        wrSlot = 1; wrIdx = 1; novoendereco = 32'h2AA; cycle("wr_in_user");
        chk("wr_in_user.erro", 32'(erro), 1);
        CSe = 1; cycle("trap2");
        flag = 2'b00; retorno = 1; procNovo = 5; cycle("bad_proc");
        chk("bad_proc.erro", 32'(erro), 1);
        chk("bad_proc.pc", 32'(endereco), ISR + 1);
        cycle("erro_clear");
        chk("erro_clear.erro", 32'(erro), 0);
        retorno = 1; procNovo = 1; cycle("restore1");
        chk("restore1.slot_untouched", 32'(endereco), 0);

        flag = 2'b01; novoendereco = 32'h3FF; cycle("jump_top");
        flag = 2'b00; cycle("wrap");
        chk("wrap.pc", 32'(endereco), 0);
        repeat (3) cycle("inc_after_wrap");
        resetBIOS = 1; CSe = 1; cycle("rbios_cse");
        chk("rbios_cse.pc", 32'(endereco), 0);
        chk("rbios_cse.modo", 32'(modo), 0);
        retorno = 1; procNovo = 1; cycle("restore1_nosave");
        chk("restore1_nosave.pc", 32'(endereco), 0);

        repeat (7) cycle("quantum_run");
        chk("quantum_run.pc", 32'(endereco), 7);
        cycle("quantum_edge");
        chk("quantum_edge.pc", 32'(endereco), QEN ? ISR : 8);
        chk("quantum_edge.preempcao", 32'(preempcao), QEN ? 1 : 0);
        CSe = 1; flag = 2'b10; cycle("to_kernel");
        retorno = 1; procNovo = 1; cycle("restore_after_q");
        chk("restore_after_q.pc", 32'(endereco), 8);
        CSe = 1; cycle("trap_again");
        // Same-edge write and restore of slot 1: restore sees the old value.
        wrSlot = 1; wrIdx = 1; novoendereco = 32'h055; retorno = 1; procNovo = 1; cycle("wr_and_restore");
        chk("wr_and_restore.pc", 32'(endereco), 8);

        for (int n = 0; n < 600; n++) begin
            flag         = 2'($urandom_range(0, 3));
            novoendereco = $urandom;
            CSe          = ($urandom_range(0, 7) == 0);
            retorno      = ($urandom_range(0, 3) == 0);
            procNovo     = PW'($urandom_range(0, 7));
            wrSlot       = ($urandom_range(0, 3) == 0);
            wrIdx        = PW'($urandom_range(0, 7));
            resetBIOS    = !retorno && ($urandom_range(0, 31) == 0);
            cycle("rand");
        end

        // Asynchronous reset between edges clears everything immediately.
        #3 reset = 0;
        #1 model_reset();
        check_all("async_reset");
        @(posedge clock);
        reset = 1;
        retorno = 1; procNovo = 2; cycle("slot_cleared");
        chk("slot_cleared.pc", 32'(endereco), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
